// File: rtl/alt_mem_ddrx_ecc_pkg.sv
// Shared types for the ECC scrub controller: FSM encoding, queue entry layout
// and the saturating counter helper. Widths here must track the top's CFG_* defaults.
package alt_mem_ddrx_ecc_pkg;

    localparam int ECC_ADDR_WIDTH = 32;
    localparam int ECC_DATA_WIDTH = 64;
    localparam int ECC_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        SCRUB_IDLE    = 2'd0,
        SCRUB_ISSUE   = 2'd1,
        SCRUB_HOLDOFF = 2'd2
    } scrub_state_e;

    typedef struct packed {
        logic [ECC_ADDR_WIDTH-1:0] addr;
        logic [ECC_DATA_WIDTH-1:0] data;
    } scrub_entry_t;

    function automatic logic [ECC_CNT_WIDTH-1:0] sat_inc(input logic [ECC_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alt_mem_ddrx_ecc_scrub_fifo.sv
// Synchronous scrub queue; a push into a full queue is accepted when a pop happens
// in the same cycle. Also exposes the address of the most recently pushed entry.
module alt_mem_ddrx_ecc_scrub_fifo
    import alt_mem_ddrx_ecc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      ctl_clk,
    input  logic                      ctl_reset,
    input  logic                      push,
    input  scrub_entry_t              push_data,
    input  logic                      pop,
    output scrub_entry_t              head_data,
    output logic [ECC_ADDR_WIDTH-1:0] tail_addr,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);

    scrub_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];
    assign tail_addr = mem[wr_ptr - 1'b1].addr;

    // NOTE: storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge ctl_clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alt_mem_ddrx_ecc_scrub_ctrl.sv
// ECC read-return error accounting and scrub write-back scheduler.
// Optional `define ALT_MEM_DDRX_ECC_SCRUB_DEDUP_EN drops SBE pushes that repeat the newest queued address.
module alt_mem_ddrx_ecc_scrub_ctrl
    import alt_mem_ddrx_ecc_pkg::*;
#(
    parameter int CFG_LOCAL_ADDR_WIDTH = ECC_ADDR_WIDTH,
    parameter int CFG_ECC_DATA_WIDTH   = ECC_DATA_WIDTH,
    parameter int CFG_ERR_CNT_WIDTH    = ECC_CNT_WIDTH,
    parameter int CFG_SCRUB_FIFO_DEPTH = 4,
    parameter int CFG_HOLDOFF_WIDTH    = 8
) (
    input  logic                            ctl_clk,
    input  logic                            ctl_reset,
    input  logic                            cfg_enable_ecc,
    input  logic                            cfg_enable_auto_corr,
    input  logic                            cfg_sbe_irq_en,
    input  logic [CFG_HOLDOFF_WIDTH-1:0]    cfg_scrub_holdoff,
    input  logic                            clr_status,
    input  logic                            rd_valid,
    input  logic [CFG_LOCAL_ADDR_WIDTH-1:0] rd_addr,
    input  logic [CFG_ECC_DATA_WIDTH-1:0]   rd_data,
    input  logic                            rd_err_sbe,
    input  logic                            rd_err_fatal,
    output logic                            scrub_req_valid,
    input  logic                            scrub_req_ready,
    output logic [CFG_LOCAL_ADDR_WIDTH-1:0] scrub_req_addr,
    output logic [CFG_ECC_DATA_WIDTH-1:0]   scrub_req_data,
    output logic [CFG_ERR_CNT_WIDTH-1:0]    sbe_count,
    output logic [CFG_ERR_CNT_WIDTH-1:0]    dbe_count,
    output logic                            err_addr_valid,
    output logic [CFG_LOCAL_ADDR_WIDTH-1:0] err_addr,
    output logic                            err_addr_fatal,
    output logic                            err_irq,
    output logic                            scrub_overflow
);

    scrub_state_e                   state;
    logic [CFG_HOLDOFF_WIDTH-1:0]   holdoff_cnt;
    logic                           is_sbe, is_fatal, is_err;
    logic                           push_req, pop, dup_hit;
    logic                           fifo_full, fifo_empty;
    scrub_entry_t                   push_entry, head_entry;
    logic [ECC_ADDR_WIDTH-1:0]      tail_addr;
    logic [CFG_ERR_CNT_WIDTH-1:0]   sbe_next, dbe_next;
    logic                           cap_valid_next, cap_fatal_next, irq_next, ovf_next;
    logic [CFG_LOCAL_ADDR_WIDTH-1:0] cap_addr_next;

    // Fatal dominates when the decoder flags both error kinds on one beat.
    assign is_fatal = rd_valid & cfg_enable_ecc & rd_err_fatal;
    assign is_sbe   = rd_valid & cfg_enable_ecc & rd_err_sbe & ~rd_err_fatal;
    assign is_err   = is_sbe | is_fatal;

`ifdef ALT_MEM_DDRX_ECC_SCRUB_DEDUP_EN
    assign dup_hit = ~fifo_empty & (tail_addr == rd_addr);
`else
    logic unused_tail;
    assign unused_tail = ^tail_addr;
    assign dup_hit     = 1'b0;
`endif

    assign push_req        = is_sbe & cfg_enable_auto_corr & ~dup_hit;
    assign pop             = (state == SCRUB_ISSUE) & scrub_req_ready;
    assign push_entry.addr = rd_addr;
    assign push_entry.data = rd_data;

    alt_mem_ddrx_ecc_scrub_fifo #(
        .DEPTH (CFG_SCRUB_FIFO_DEPTH)
    ) u_scrub_fifo (
        .ctl_clk   (ctl_clk),
        .ctl_reset (ctl_reset),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .tail_addr (tail_addr),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: every value is defaulted before any conditional update so no latch is inferred.
    always_comb begin
        sbe_next       = clr_status ? '0 : sbe_count;
        dbe_next       = clr_status ? '0 : dbe_count;
        cap_valid_next = clr_status ? 1'b0 : err_addr_valid;
        cap_addr_next  = clr_status ? '0 : err_addr;
        cap_fatal_next = clr_status ? 1'b0 : err_addr_fatal;
        irq_next       = clr_status ? 1'b0 : err_irq;
        ovf_next       = clr_status ? 1'b0 : scrub_overflow;
        if (is_sbe)
            sbe_next = sat_inc(sbe_next);
        if (is_fatal)
            dbe_next = sat_inc(dbe_next);
        if (is_err && !cap_valid_next) begin
            cap_valid_next = 1'b1;
            cap_addr_next  = rd_addr;
            cap_fatal_next = is_fatal;
        end
        if (is_fatal || (is_sbe && cfg_sbe_irq_en))
            irq_next = 1'b1;
        if (push_req && fifo_full && !pop)
            ovf_next = 1'b1;
    end

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            sbe_count      <= '0;
            dbe_count      <= '0;
            err_addr_valid <= 1'b0;
            err_addr       <= '0;
            err_addr_fatal <= 1'b0;
            err_irq        <= 1'b0;
            scrub_overflow <= 1'b0;
        end else begin
            sbe_count      <= sbe_next;
            dbe_count      <= dbe_next;
            err_addr_valid <= cap_valid_next;
            err_addr       <= cap_addr_next;
            err_addr_fatal <= cap_fatal_next;
            err_irq        <= irq_next;
            scrub_overflow <= ovf_next;
        end
    end

    // Request outputs are loaded on entry to ISSUE and held until the handshake.
    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            state           <= SCRUB_IDLE;
            holdoff_cnt     <= '0;
            scrub_req_valid <= 1'b0;
            scrub_req_addr  <= '0;
            scrub_req_data  <= '0;
        end else begin
            case (state)
                SCRUB_IDLE: begin
                    if (!fifo_empty) begin
                        state           <= SCRUB_ISSUE;
                        scrub_req_valid <= 1'b1;
                        scrub_req_addr  <= head_entry.addr;
                        scrub_req_data  <= head_entry.data;
                    end
                end
                SCRUB_ISSUE: begin
                    if (scrub_req_ready) begin
                        scrub_req_valid <= 1'b0;
                        scrub_req_addr  <= '0;
                        scrub_req_data  <= '0;
                        if (cfg_scrub_holdoff == '0) begin
                            state <= SCRUB_IDLE;
                        end else begin
                            holdoff_cnt <= cfg_scrub_holdoff;
                            state       <= SCRUB_HOLDOFF;
                        end
                    end
                end
                SCRUB_HOLDOFF: begin
                    if (holdoff_cnt <= CFG_HOLDOFF_WIDTH'(1)) begin
                        holdoff_cnt <= '0;
                        state       <= SCRUB_IDLE;
                    end else begin
                        holdoff_cnt <= holdoff_cnt - 1'b1;
                    end
                end
                default: state <= SCRUB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alt_mem_ddrx_ecc_scrub_ctrl.sv
// Directed self-checking bench for alt_mem_ddrx_ecc_scrub_ctrl; expectations are hand-computed.
// Build with +define+ALT_MEM_DDRX_ECC_SCRUB_DEDUP_EN to exercise the dedup variant.
module tb_alt_mem_ddrx_ecc_scrub_ctrl;

    logic        ctl_clk = 1'b0;
    logic        ctl_reset;
    logic        cfg_enable_ecc, cfg_enable_auto_corr, cfg_sbe_irq_en;
    logic [7:0]  cfg_scrub_holdoff;
    logic        clr_status;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic [63:0] rd_data;
    logic        rd_err_sbe, rd_err_fatal;
    logic        scrub_req_valid, scrub_req_ready;
    logic [31:0] scrub_req_addr;
    logic [63:0] scrub_req_data;
    logic [15:0] sbe_count, dbe_count;
    logic        err_addr_valid;
    logic [31:0] err_addr;
    logic        err_addr_fatal, err_irq, scrub_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] log_addr[$];
    logic [63:0] log_data[$];

`ifdef ALT_MEM_DDRX_ECC_SCRUB_DEDUP_EN
    localparam int EXP_DEDUP_ENTRIES = 1;
`else
    localparam int EXP_DEDUP_ENTRIES = 2;
`endif

    alt_mem_ddrx_ecc_scrub_ctrl dut (
        .ctl_clk              (ctl_clk),
        .ctl_reset            (ctl_reset),
        .cfg_enable_ecc       (cfg_enable_ecc),
        .cfg_enable_auto_corr (cfg_enable_auto_corr),
        .cfg_sbe_irq_en       (cfg_sbe_irq_en),
        .cfg_scrub_holdoff    (cfg_scrub_holdoff),
        .clr_status           (clr_status),
        .rd_valid             (rd_valid),
        .rd_addr              (rd_addr),
        .rd_data              (rd_data),
        .rd_err_sbe           (rd_err_sbe),
        .rd_err_fatal         (rd_err_fatal),
        .scrub_req_valid      (scrub_req_valid),
        .scrub_req_ready      (scrub_req_ready),
        .scrub_req_addr       (scrub_req_addr),
        .scrub_req_data       (scrub_req_data),
        .sbe_count            (sbe_count),
        .dbe_count            (dbe_count),
        .err_addr_valid       (err_addr_valid),
        .err_addr             (err_addr),
        .err_addr_fatal       (err_addr_fatal),
        .err_irq              (err_irq),
        .scrub_overflow       (scrub_overflow)
    );

    always #5 ctl_clk = ~ctl_clk;

    // Handshakes are recorded mid-cycle, when both valid and ready are settled.
    always @(negedge ctl_clk) begin
        if (scrub_req_valid && scrub_req_ready) begin
            log_addr.push_back(scrub_req_addr);
            log_data.push_back(scrub_req_data);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dat(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    function automatic logic [31:0] log_a(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [63:0] log_d(input int i);
        return (i < log_data.size()) ? log_data[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic tick();
        @(posedge ctl_clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] a, input logic sbe, input logic fatal);
        rd_valid     = 1'b1;
        rd_addr      = a;
        rd_data      = dat(a);
        rd_err_sbe   = sbe;
        rd_err_fatal = fatal;
        tick();
        rd_valid     = 1'b0;
        rd_err_sbe   = 1'b0;
        rd_err_fatal = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int cyc = 0;
        while (log_addr.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        check({tag, "_handshakes"}, 64'(log_addr.size()), 64'(n));
    endtask

    initial begin
        ctl_reset            = 1'b1;
        cfg_enable_ecc       = 1'b1;
        cfg_enable_auto_corr = 1'b1;
        cfg_sbe_irq_en       = 1'b0;
        cfg_scrub_holdoff    = 8'd0;
        clr_status           = 1'b0;
        rd_valid             = 1'b0;
        rd_addr              = '0;
        rd_data              = '0;
        rd_err_sbe           = 1'b0;
        rd_err_fatal         = 1'b0;
        scrub_req_ready      = 1'b1;
        tick();
        tick();
        ctl_reset = 1'b0;
        tick();

        check("rst_valid", scrub_req_valid, 0);
        check("rst_addr", scrub_req_addr, 0);
        check("rst_data", scrub_req_data, 0);
        check("rst_sbe", sbe_count, 0);
        check("rst_dbe", dbe_count, 0);
        check("rst_cap_valid", err_addr_valid, 0);
        check("rst_irq", err_irq, 0);
        check("rst_ovf", scrub_overflow, 0);

        // Three SBEs, ready high: in-order write-backs, 2-cycle request latency.
        log_addr.delete(); log_data.delete();
        beat(32'h100, 1, 0);
        check("t1_lat_cyc1_valid", scrub_req_valid, 0);
        check("t1_sbe_after1", sbe_count, 1);
        beat(32'h140, 1, 0);
        check("t1_lat_cyc2_valid", scrub_req_valid, 1);
        check("t1_lat_cyc2_addr", scrub_req_addr, 32'h100);
        beat(32'h180, 1, 0);
        wait_log(3, 40, "t1");
        check("t1_req0_addr", log_a(0), 32'h100);
        check("t1_req1_addr", log_a(1), 32'h140);
        check("t1_req2_addr", log_a(2), 32'h180);
        check("t1_req0_data", log_d(0), dat(32'h100));
        check("t1_req2_data", log_d(2), dat(32'h180));
        check("t1_sbe", sbe_count, 3);
        check("t1_dbe", dbe_count, 0);
        check("t1_err_addr", err_addr, 32'h100);
        check("t1_err_fatal", err_addr_fatal, 0);
        check("t1_irq", err_irq, 0);
        repeat (5) tick();

        // Fatal beat: irq without SBE irq enable, no scrub; both flags -> fatal only.
        pulse_clr();
        log_addr.delete(); log_data.delete();
        beat(32'h200, 0, 1);
        check("t2_irq", err_irq, 1);
        check("t2_dbe", dbe_count, 1);
        check("t2_err_addr", err_addr, 32'h200);
        check("t2_err_fatal", err_addr_fatal, 1);
        beat(32'h240, 1, 1);
        check("t2_both_dbe", dbe_count, 2);
        check("t2_both_sbe", sbe_count, 0);
        check("t2_err_addr_kept", err_addr, 32'h200);
        repeat (10) tick();
        check("t2_no_scrub", 64'(log_addr.size()), 0);
        pulse_clr();
        check("t2_clr_sbe", sbe_count, 0);
        check("t2_clr_dbe", dbe_count, 0);
        check("t2_clr_cap_valid", err_addr_valid, 0);
        check("t2_clr_err_addr", err_addr, 0);
        check("t2_clr_fatal", err_addr_fatal, 0);
        check("t2_clr_irq", err_irq, 0);

        // Ready low, six SBEs into a depth-4 queue: overflow and a stable request.
        scrub_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            beat(32'h500 + 32'(i) * 32'h40, 1, 0);
            if (i >= 1) begin
                check("t3_hold_valid", scrub_req_valid, 1);
                check("t3_hold_addr", scrub_req_addr, 32'h500);
                check("t3_hold_data", scrub_req_data, dat(32'h500));
            end
        end
        check("t3_ovf", scrub_overflow, 1);
        check("t3_sbe", sbe_count, 6);
        pulse_clr();
        check("t3_clr_ovf", scrub_overflow, 0);
        check("t3_clr_keeps_req", scrub_req_valid, 1);
        // Push into a full queue while the head is popped: accepted, no overflow.
        log_addr.delete(); log_data.delete();
        scrub_req_ready = 1'b1;
        beat(32'h600, 1, 0);
        check("t3_pushpop_ovf", scrub_overflow, 0);
        wait_log(5, 60, "t3");
        check("t3_req0_addr", log_a(0), 32'h500);
        check("t3_req1_addr", log_a(1), 32'h540);
        check("t3_req2_addr", log_a(2), 32'h580);
        check("t3_req3_addr", log_a(3), 32'h5C0);
        check("t3_req4_addr", log_a(4), 32'h600);
        check("t3_req4_data", log_d(4), dat(32'h600));
        repeat (5) tick();

        // ECC disabled: beat is ignored entirely.
        cfg_enable_ecc = 1'b0;
        beat(32'h800, 1, 0);
        repeat (4) tick();
        check("en_off_sbe", sbe_count, 1);
        check("en_off_valid", scrub_req_valid, 0);
        cfg_enable_ecc = 1'b1;

        // Hold-off of 5: valid low for 5 hold-off cycles plus one IDLE cycle.
        cfg_scrub_holdoff = 8'd5;
        scrub_req_ready   = 1'b0;
        beat(32'h700, 1, 0);
        beat(32'h740, 1, 0);
        check("t4_first_valid", scrub_req_valid, 1);
        scrub_req_ready = 1'b1;
        tick();
        check("t4_handshake_drop", scrub_req_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_gap_valid", scrub_req_valid, 0);
        end
        tick();
        check("t4_second_valid", scrub_req_valid, 1);
        check("t4_second_addr", scrub_req_addr, 32'h740);
        repeat (10) tick();
        cfg_scrub_holdoff = 8'd0;

        // clr_status with a coincident SBE: clear first, then record.
        cfg_sbe_irq_en = 1'b1;
        clr_status = 1'b1;
        beat(32'h300, 1, 0);
        clr_status = 1'b0;
        check("t5_sbe", sbe_count, 1);
        check("t5_err_addr", err_addr, 32'h300);
        check("t5_cap_valid", err_addr_valid, 1);
        check("t5_irq", err_irq, 1);
        // Saturation: drive SBEs up to all-ones, then one more.
        cfg_enable_auto_corr = 1'b0;
        rd_valid   = 1'b1;
        rd_addr    = 32'h310;
        rd_data    = dat(32'h310);
        rd_err_sbe = 1'b1;
        repeat (65534) tick();
        check("t5_sbe_full", sbe_count, 16'hFFFF);
        tick();
        rd_valid   = 1'b0;
        rd_err_sbe = 1'b0;
        check("t5_sbe_sat", sbe_count, 16'hFFFF);
        check("t5_dbe_unchanged", dbe_count, 0);
        check("t5_err_addr_kept", err_addr, 32'h300);
        cfg_enable_auto_corr = 1'b1;
        cfg_sbe_irq_en       = 1'b0;
        repeat (5) tick();

        // Repeated SBE address while the queue holds it.
        pulse_clr();
        scrub_req_ready = 1'b0;
        beat(32'h400, 1, 0);
        beat(32'h400, 1, 0);
        check("t6_sbe", sbe_count, 2);
        check("t6_ovf", scrub_overflow, 0);
        log_addr.delete(); log_data.delete();
        scrub_req_ready = 1'b1;
        repeat (20) tick();
        check("t6_entries", 64'(log_addr.size()), 64'(EXP_DEDUP_ENTRIES));
        check("t6_addr", log_a(0), 32'h400);

        // Reset mid-handshake: request drops next cycle, queue is emptied.
        scrub_req_ready = 1'b0;
        beat(32'h900, 1, 0);
        beat(32'h940, 1, 0);
        check("t7_pre_valid", scrub_req_valid, 1);
        ctl_reset = 1'b1;
        tick();
        check("t7_rst_valid", scrub_req_valid, 0);
        check("t7_rst_addr", scrub_req_addr, 0);
        ctl_reset = 1'b0;
        repeat (5) tick();
        check("t7_empty_valid", scrub_req_valid, 0);
        check("t7_rst_sbe", sbe_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alt_mem_ddrx_ecc_scrub_ctrl.md
Name: alt_mem_ddrx_ecc_scrub_ctrl

Overview:
Sits downstream of the ECC decoder in the DDRx controller read return path. Per valid read beat it:
- counts correctable (SBE) and uncorrectable (fatal) errors;
- captures the first error address and raises a sticky interrupt;
- queues corrected data for write-back (scrub) to DRAM through a valid/ready request port.
A small FSM drains the scrub queue with a programmable hold-off between write-backs so scrubs do not starve normal traffic.

Parameters:
CFG_LOCAL_ADDR_WIDTH, 32, width of local beat address
CFG_ECC_DATA_WIDTH, 64, corrected data width per beat (data portion only, no ECC code)
CFG_ERR_CNT_WIDTH, 16, width of saturating error counters
CFG_SCRUB_FIFO_DEPTH, 4, scrub queue entries; power of 2, >=2
CFG_HOLDOFF_WIDTH, 8, width of hold-off counter

Ports:
ctl_clk  in  1  controller clock
ctl_reset  in  1  synchronous active-high reset
cfg_enable_ecc  in  1  0: block idle, no counting/queuing/irq
cfg_enable_auto_corr  in  1  1: enqueue SBE beats for scrub
cfg_sbe_irq_en  in  1  1: SBE also raises err_irq
cfg_scrub_holdoff  in  CFG_HOLDOFF_WIDTH  idle cycles after each accepted scrub
clr_status  in  1  single-cycle pulse: clear counters, capture, irq, overflow
rd_valid  in  1  decoder output beat valid
rd_addr  in  CFG_LOCAL_ADDR_WIDTH  address of beat
rd_data  in  CFG_ECC_DATA_WIDTH  corrected data from decoder
rd_err_sbe  in  1  single-bit error corrected on this beat
rd_err_fatal  in  1  uncorrectable error on this beat
scrub_req_valid  out  1  write-back request valid
scrub_req_ready  in  1  command path accepts request
scrub_req_addr  out  CFG_LOCAL_ADDR_WIDTH  write-back address
scrub_req_data  out  CFG_ECC_DATA_WIDTH  write-back data
sbe_count  out  CFG_ERR_CNT_WIDTH  saturating SBE count
dbe_count  out  CFG_ERR_CNT_WIDTH  saturating fatal count
err_addr_valid  out  1  first-error capture holds data
err_addr  out  CFG_LOCAL_ADDR_WIDTH  address of first error since clear
err_addr_fatal  out  1  captured error was fatal
err_irq  out  1  sticky interrupt
scrub_overflow  out  1  sticky; a scrub was dropped because the queue was full

Behaviour:
- Reset: every output is 0, queue empty, FSM in IDLE, hold-off counter 0.
- Qualified beat = rd_valid & cfg_enable_ecc. A beat with both rd_err_sbe and rd_err_fatal set is treated as fatal only.
- Counters:
  - Registered; update the cycle after a qualified error beat.
  - Saturate at all-ones and never wrap.
- clr_status:
  - Clears counters, capture, err_irq and scrub_overflow.
  - If an error beat coincides with clr_status, the clear applies first and the beat is then recorded: count = 1, capture loaded, irq set if enabled.
- Capture:
  - Loads on the first qualified error beat while err_addr_valid = 0.
  - Later errors do not overwrite it.
- err_irq:
  - Set the cycle after a fatal beat, or an SBE beat when cfg_sbe_irq_en = 1.
  - Held until clr_status.
- Enqueue: qualified SBE beat (not fatal) with cfg_enable_auto_corr = 1 pushes {rd_addr, rd_data}.
  - Queue full: entry dropped, scrub_overflow set.
  - Simultaneous push and pop on a full queue is permitted; the push succeeds.
- Scrub FSM:
  - IDLE: queue not empty -> ISSUE.
  - ISSUE:
    - scrub_req_valid = 1 with the head entry.
    - Valid, addr and data stay stable until scrub_req_ready.
    - On valid & ready: pop the entry. If cfg_scrub_holdoff = 0, go to IDLE; else load the counter and go to HOLDOFF.
  - HOLDOFF: decrement each cycle; -> IDLE when the count reaches 1, giving exactly cfg_scrub_holdoff idle cycles.
- Latency: an SBE beat into an empty queue with ready held high gives scrub_req_valid 2 cycles after rd_valid (enqueue cycle + IDLE->ISSUE).
- cfg_enable_ecc deasserted mid-operation: the current ISSUE handshake still completes; queue contents remain and continue to drain.
- clr_status does not flush the queue.
- ctl_reset mid-handshake: scrub_req_valid drops the next cycle and the queue is emptied.

Optional Feature:
ALT_MEM_DDRX_ECC_SCRUB_DEDUP_EN
- Defined: an SBE push whose rd_addr equals the address of the most recently enqueued entry still resident in the queue is silently dropped. The count is still incremented; scrub_overflow is not set.
- Undefined: every qualifying SBE beat is pushed.

Decomposition:
- Package alt_mem_ddrx_ecc_pkg holds:
  - scrub FSM state encoding (IDLE, ISSUE, HOLDOFF);
  - the scrub entry struct {addr, data};
  - the saturating-increment function.
- One sub-module, alt_mem_ddrx_ecc_scrub_fifo: synchronous FIFO with full/empty flags and simultaneous push/pop, instantiated for the queue.

Test Plan:
- Three SBE beats at 0x100, 0x140, 0x180; ready = 1; holdoff = 0 -> three requests in order, sbe_count = 3, err_addr = 0x100, err_addr_fatal = 0, dbe_count = 0.
- Fatal beat at 0x200 with cfg_sbe_irq_en = 0 -> err_irq = 1 next cycle, dbe_count = 1, no scrub request; clr_status -> all status outputs 0.
- ready = 0 and six SBE beats with depth 4 -> 4 queued, scrub_overflow = 1; valid, addr and data held stable throughout.
- holdoff = 5, two queued entries, ready = 1 -> second valid rises exactly 5 idle cycles after the first handshake plus the IDLE cycle.
- clr_status coincident with an SBE at 0x300 -> sbe_count = 1, err_addr = 0x300; counter preloaded to 0xFFFF stays at 0xFFFF on a further SBE.
- With DEDUP_EN, two consecutive SBEs at 0x400 while ready = 0 -> one queue entry, sbe_count = 2.
